// File: rtl/wb_pkg.sv
// Shared types for the writeback arbiter: state encoding and the
// buffered result record (destination register + data).
package wb_pkg;

    localparam int WB_XLEN   = 32;
    localparam int WB_REG_AW = 5;

    typedef enum logic {
        WB_NORMAL = 1'b0,
        WB_DRAIN  = 1'b1
    } wb_state_t;

    typedef struct packed {
        logic [WB_REG_AW-1:0] rd;
        logic [WB_XLEN-1:0]   data;
    } wb_req_t;

endpackage

// File: rtl/wb_arbiter_if.sv
// Bundle of the two result streams into the arbiter and the regfile
// write port out of it. master = producer/consumer side, slave = arbiter.
interface wb_arbiter_if #(
    parameter int XLEN       = 32,
    parameter int REG_AW     = 5,
    parameter int FIFO_DEPTH = 4
);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    // in-order pipeline result
    logic              a_valid;
    logic              a_ready;
    logic [REG_AW-1:0] a_rd;
    logic [XLEN-1:0]   a_data;

    // multi-cycle unit result
    logic              b_valid;
    logic              b_ready;
    logic [REG_AW-1:0] b_rd;
    logic [XLEN-1:0]   b_data;

    // regfile write port
    logic              we;
    logic [REG_AW-1:0] rd_addr;
    logic [XLEN-1:0]   w_data;
    logic [CNT_W-1:0]  b_pending;

    modport master (
        output a_valid, a_rd, a_data, b_valid, b_rd, b_data,
        input  a_ready, b_ready, we, rd_addr, w_data, b_pending
    );

    modport slave (
        input  a_valid, a_rd, a_data, b_valid, b_rd, b_data,
        output a_ready, b_ready, we, rd_addr, w_data, b_pending
    );

endinterface

// File: rtl/wb_fifo.sv
// Synchronous FIFO for buffered B results. No fall-through: dout shows
// the entry at the read pointer, so a freshly pushed entry is only
// visible once count reflects it on the following cycle.
module wb_fifo
    import wb_pkg::*;
#(
    parameter int  DEPTH = 4,
    parameter type T     = wb_req_t,
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic          pop,
    input  T              din,
    output T              dout,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);

    T              mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    // Guard against caller misuse so the pointers never run past each other
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);
    assign dout  = mem[rd_ptr];

    // Storage write; contents need no reset since count gates visibility
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    // Pointer and occupancy update; pointers wrap naturally at DEPTH (power of two)
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges the in-order pipeline result (A) and the
// buffered multi-cycle result stream (B) onto one registered regfile
// write port. Once B backs up past DRAIN_THRESH the pipeline is stalled
// until the B FIFO empties, so B results cannot starve.
// Optional: define WB_ARBITER_PERF_EN to add perf_stall_cnt, counting
// cycles in which a valid A result is held off by DRAIN.
module wb_arbiter
    import wb_pkg::*;
#(
    parameter int  XLEN         = WB_XLEN,
    parameter int  REG_AW       = WB_REG_AW,
    parameter int  FIFO_DEPTH   = 4,
    parameter int  DRAIN_THRESH = 3,
    localparam int CW           = $clog2(FIFO_DEPTH) + 1
) (
    input  logic        clk,
    input  logic        reset,
    wb_arbiter_if.slave bus
`ifdef WB_ARBITER_PERF_EN
    ,
    output logic [31:0] perf_stall_cnt
`endif
);

    typedef struct packed {
        logic [REG_AW-1:0] rd;
        logic [XLEN-1:0]   data;
    } req_t;

    wb_state_t         state;
    req_t              fifo_din;
    req_t              fifo_dout;
    req_t              sel;
    logic [CW-1:0]     fifo_count;
    logic [CW-1:0]     count_next;
    logic              fifo_full;
    logic              fifo_empty;
    logic              push;
    logic              pop;
    logic              a_take;
    logic              sel_vld;
    logic              we_q;
    logic [REG_AW-1:0] rd_addr_q;
    logic [XLEN-1:0]   w_data_q;

    assign fifo_din.rd   = bus.b_rd;
    assign fifo_din.data = bus.b_data;

    wb_fifo #(
        .DEPTH (FIFO_DEPTH),
        .T     (req_t)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   (fifo_din),
        .dout  (fifo_dout),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Handshakes come straight off registered state so neither ready
    // depends on this cycle's valids or pop decision
    assign bus.a_ready   = (state == WB_NORMAL);
    assign bus.b_ready   = !fifo_full;
    assign bus.b_pending = fifo_count;
    assign push          = bus.b_valid && !fifo_full;

    // Source select: A wins in NORMAL, otherwise the FIFO head drains
    always_comb begin
        a_take     = (state == WB_NORMAL) && bus.a_valid;
        pop        = !fifo_empty && !a_take;
        sel_vld    = a_take || pop;
        sel        = fifo_dout;
        if (a_take) begin
            sel.rd   = bus.a_rd;
            sel.data = bus.a_data;
        end
        count_next = fifo_count + CW'(push) - CW'(pop);
    end

    // Drain state machine and the registered regfile write port
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= WB_NORMAL;
            we_q      <= 1'b0;
            rd_addr_q <= '0;
            w_data_q  <= '0;
        end else begin
            case (state)
                WB_NORMAL: if (count_next >= CW'(DRAIN_THRESH)) state <= WB_DRAIN;
                WB_DRAIN:  if (count_next == '0)                 state <= WB_NORMAL;
                default:   state <= WB_NORMAL;
            endcase
            // Writes to x0 are consumed but never reach the regfile
            we_q <= sel_vld && (sel.rd != '0);
            if (sel_vld && (sel.rd != '0)) begin
                rd_addr_q <= sel.rd;
                w_data_q  <= sel.data;
            end
        end
    end

    assign bus.we      = we_q;
    assign bus.rd_addr = rd_addr_q;
    assign bus.w_data  = w_data_q;

`ifdef WB_ARBITER_PERF_EN
    // Cycles a pipeline result sat waiting because B was draining
    always_ff @(posedge clk) begin
        if (reset)
            perf_stall_cnt <= '0;
        else if (state == WB_DRAIN && bus.a_valid)
            perf_stall_cnt <= perf_stall_cnt + 32'd1;
    end
`endif

endmodule

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
- Writeback arbiter directly upstream of the register file.
- Merges two result streams into the single regfile write port (we, rd_addr, w_data):
  - the in-order single-cycle pipeline result (port A);
  - the out-of-order multi-cycle unit result from MUL/DIV/LSU (port B).
- Port B results are buffered in a small FIFO.
- A drain state machine stalls the pipeline when that FIFO backs up, preventing B starvation.

Parameters:
- XLEN, 32, data width.
- REG_AW, 5, register address width.
- FIFO_DEPTH, 4, B-result FIFO entries; power of two, >= 2.
- DRAIN_THRESH, 3, FIFO occupancy that forces DRAIN; 1 <= DRAIN_THRESH <= FIFO_DEPTH.

Ports:
- clk  in  1  clock, all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- a_valid  in  1  pipeline result valid.
- a_ready  out  1  pipeline result accepted this cycle.
- a_rd  in  REG_AW  pipeline destination register.
- a_data  in  XLEN  pipeline result data.
- b_valid  in  1  multi-cycle result valid.
- b_ready  out  1  FIFO can accept a B result.
- b_rd  in  REG_AW  multi-cycle destination register.
- b_data  in  XLEN  multi-cycle result data.
- we  out  1  regfile write enable, registered.
- rd_addr  out  REG_AW  regfile write address, registered.
- w_data  out  XLEN  regfile write data, registered.
- b_pending  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Behaviour:
- Clock and reset: single clock clk; reset is synchronous and active-high.
- Reset values: we=0, rd_addr=0, w_data=0, b_pending=0, state=NORMAL, FIFO emptied (contents discarded).
  - A reset mid-operation drops all buffered B results.
  - b_ready=1 and a_ready=1 from the first cycle after reset deasserts.
- b_ready = (count < FIFO_DEPTH).
  - Depends on registered count only; no combinational path from pop.
  - Push on b_valid && b_ready.
- Handshake: valid/ready.
  - Upstream holds a_valid/a_rd/a_data and b_* stable until accepted.
  - Unaccepted beats are not lost.
- State NORMAL: a_ready=1.
  - If a_valid, the A result is selected.
  - Else, if FIFO non-empty, the FIFO head is popped and selected.
  - Else, nothing is selected.
- State DRAIN: a_ready=0; the FIFO head is popped and selected each cycle it is non-empty.
- Transitions (on count_next, the post-push/pop occupancy):
  - NORMAL -> DRAIN when count_next >= DRAIN_THRESH.
  - DRAIN -> NORMAL when count_next == 0.
- Write register update:
  - Entry selected with rd != 0: we<=1, rd_addr<=rd, w_data<=data.
  - Entry selected with rd == 0: entry consumed, we<=0.
  - Nothing selected: we<=0; rd_addr and w_data hold their values.
- Latency:
  - A: accept to we is 1 cycle.
  - B: push to we is at least 2 cycles. An entry pushed into an empty FIFO is not poppable in the same cycle (no fall-through).
- Simultaneous push and pop: count unchanged; order preserved.
- Push while full: impossible, since b_ready=0.
- FIFO pointers wrap modulo FIFO_DEPTH.
- B results are written in FIFO (arrival) order.
- WAW ordering between A and B is the issue logic's responsibility (scoreboard); this block does not check it.
- b_pending = count (registered).

Optional Feature:
- Macro: WB_ARBITER_PERF_EN.
- Defined:
  - Adds output perf_stall_cnt (32 bits).
  - Increments each cycle with state==DRAIN && a_valid.
  - Wraps at 2^32; resets to 0 on reset.
- Undefined: the port and the counter are absent; all other behaviour is identical.

Decomposition:
- Package wb_pkg:
  - wb_state_t enum {WB_NORMAL, WB_DRAIN};
  - wb_req_t packed struct {rd[REG_AW-1:0], data[XLEN-1:0]};
  - localparams for default XLEN/REG_AW.
- Sub-module wb_fifo:
  - synchronous FIFO of wb_req_t;
  - ports: clk, reset, push, pop, din, dout, count, full, empty; parameter DEPTH.
  - Pointers are log2(DEPTH) bits plus a separate count register.
- wb_arbiter instantiates one wb_fifo and holds the state machine plus the output register.

Test Plan:
- Reset, then a_valid=1, a_rd=5, a_data=0xDEADBEEF for 1 cycle -> next cycle we=1, rd_addr=5, w_data=0xDEADBEEF; following cycle we=0.
- a_rd=0, a_data=0x1234 -> a_ready=1, entry consumed, we stays 0; rd_addr/w_data unchanged.
- a_valid=0, b_valid=1, b_rd=7, b_data=0x55 for 1 cycle -> b_pending=1 next cycle; we=1, rd_addr=7 two cycles after push; b_pending back to 0.
- a_valid held 1 continuously, 3 B pushes (rd 1,2,3) -> b_pending reaches 3, state DRAIN, a_ready=0.
  - Writes rd 1,2,3 occur in order on consecutive cycles; then a_ready=1.
  - With WB_ARBITER_PERF_EN, perf_stall_cnt=3.
- b_valid held 1 with a_valid=1 and DRAIN_THRESH=FIFO_DEPTH=4 -> b_ready=0 after 4 pushes; no push lost; simultaneous push/pop keeps b_pending constant.
- Assert reset with b_pending=2 in DRAIN -> next cycle b_pending=0, we=0, a_ready=1, b_ready=1; discarded entries never written.
